// File: rtl/pipe_pkg.sv
// Shared types for the pipeline bus arbiter: FSM states, requester IDs, bubble opcode.
// Pure declarations; no timing or flow control of its own.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2,
        REQ_DMA   = 2'd3
    } req_id_t;

    // Opcode the Pipeline loads into stage 0 when FetchBubble is high.
    localparam logic [7:0] NOP_OPCODE = 8'h00;

endpackage

// File: rtl/pipe_burst_limiter.sv
// Counts consecutive DMA grants and reports whether another one may go ahead of fetch.
// Registered counter, combinational dma_ok_o; clears on a fetch grant or an idle DMA cycle.
module pipe_burst_limiter #(
    parameter int DMA_MAX_BURST = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dma_req_i,
    input  logic gnt_dma_i,
    input  logic gnt_fetch_i,
    output logic dma_ok_o
);

    localparam int CNT_W = $clog2(DMA_MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX_BURST);

    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;

    // A data grant neither advances nor clears the count, so the limit survives stage-2 traffic.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (gnt_fetch_i || !dma_req_i) begin
            burst_cnt_d = '0;
        end else if (gnt_dma_i && (burst_cnt_q != CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign dma_ok_o = (burst_cnt_q < CNT_MAX);

endmodule

// File: rtl/pipeline_bus_arbiter.sv
// Shares the 8-bit memory bus between stage-2 data, DMA and stage-0 fetch; flushes the pipe after reset.
// Zero-latency grant/strobe; losers simply see no grant, fetch gets FetchBubble/PcHold.
module pipeline_bus_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int FLUSH_CYCLES  = 3,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic              ClockIn,
    input  logic              ResetIn,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    input  logic              DataReq,
    input  logic              DataWrite,
    input  logic [ADDR_W-1:0] DataAddr,
    input  logic [7:0]        DataWData,
    input  logic              DmaReq,
    input  logic              DmaWrite,
    input  logic [ADDR_W-1:0] DmaAddr,
    input  logic [7:0]        DmaWData,
    output logic              GntFetch,
    output logic              GntData,
    output logic              GntDma,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWData,
    output logic              MemWE,
    output logic              MemRE,
    output logic              FetchBubble,
    output logic              PcHold
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    arb_state_t      state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    req_id_t         grant;
    logic            dma_ok;

    always_ff @(posedge ClockIn) begin
        if (ResetIn) begin
            state_q     <= S_RESET;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        grant       = REQ_NONE;
        case (state_q)
            S_RESET: begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
            end
            S_FLUSH: begin
                // Pipeline is empty, so only DMA can use the bus; no fetch to protect yet.
                if (DmaReq) begin
                    grant = REQ_DMA;
                end
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = S_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (DataReq) begin
                    grant = REQ_DATA;
                end else if (DmaReq && (dma_ok || !FetchReq)) begin
                    grant = REQ_DMA;
                end else if (FetchReq) begin
                    grant = REQ_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
        // Reset kills any access in the very cycle it is raised.
        if (ResetIn) begin
            grant = REQ_NONE;
        end
    end

    pipe_burst_limiter #(
        .DMA_MAX_BURST(DMA_MAX_BURST)
    ) u_burst (
        .clk_i      (ClockIn),
        .rst_i      (ResetIn),
        .dma_req_i  (DmaReq),
        .gnt_dma_i  (grant == REQ_DMA),
        .gnt_fetch_i(grant == REQ_FETCH),
        .dma_ok_o   (dma_ok)
    );

    always_comb begin
        MemAddr  = '0;
        MemWData = '0;
        MemWE    = 1'b0;
        MemRE    = 1'b0;
        case (grant)
            REQ_FETCH: begin
                MemAddr = FetchAddr;
                MemRE   = 1'b1;
            end
            REQ_DATA: begin
                MemAddr  = DataAddr;
                MemWE    = DataWrite;
                MemRE    = !DataWrite;
                MemWData = DataWrite ? DataWData : 8'h00;
            end
            REQ_DMA: begin
                MemAddr  = DmaAddr;
                MemWE    = DmaWrite;
                MemRE    = !DmaWrite;
                MemWData = DmaWrite ? DmaWData : 8'h00;
            end
            default: ;
        endcase
    end

    assign GntFetch    = (grant == REQ_FETCH);
    assign GntData     = (grant == REQ_DATA);
    assign GntDma      = (grant == REQ_DMA);
    assign FetchBubble = !GntFetch;
    assign PcHold      = FetchBubble;

endmodule

// File: tb/tb_pipeline_bus_arbiter.sv
// Directed bench for pipeline_bus_arbiter: scenario tasks with hand-computed expectations.
module tb_pipeline_bus_arbiter;
    import pipe_pkg::*;

    localparam int ADDR_W = 16;
    localparam int FLUSH  = 3;

    logic              ClockIn = 1'b0;
    logic              ResetIn;
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              DataReq;
    logic              DataWrite;
    logic [ADDR_W-1:0] DataAddr;
    logic [7:0]        DataWData;
    logic              DmaReq;
    logic              DmaWrite;
    logic [ADDR_W-1:0] DmaAddr;
    logic [7:0]        DmaWData;
    logic              GntFetch, GntData, GntDma;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemWData;
    logic              MemWE, MemRE, FetchBubble, PcHold;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    pipeline_bus_arbiter #(
        .ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH), .DMA_MAX_BURST(4)
    ) dut (
        .ClockIn(ClockIn), .ResetIn(ResetIn),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr),
        .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataWData(DataWData),
        .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
        .GntFetch(GntFetch), .GntData(GntData), .GntDma(GntDma),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE),
        .FetchBubble(FetchBubble), .PcHold(PcHold)
    );

    always #5 ClockIn = ~ClockIn;

    // Inputs change at posedge+1 and are checked at posedge+3; invariants run on the negedge.
    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    always @(negedge ClockIn) begin
        if (!done) begin
            total++;
            if ((int'(GntFetch) + int'(GntData) + int'(GntDma)) > 1) begin
                bad++;
                $display("FAIL onehot_grant: got F=%b D=%b M=%b want at most one", GntFetch, GntData, GntDma);
            end
            total++;
            if (MemWE && MemRE) begin
                bad++;
                $display("FAIL we_re_exclusive: got WE=%b RE=%b want not both", MemWE, MemRE);
            end
            if (dut.state_q == S_RUN && !ResetIn) begin
                total++;
                if (FetchBubble !== !GntFetch || PcHold !== FetchBubble) begin
                    bad++;
                    $display("FAIL bubble_run: got bubble=%b hold=%b gntfetch=%b want bubble=hold=!gntfetch",
                             FetchBubble, PcHold, GntFetch);
                end
            end
        end
    end

    task automatic test_reset();
        ResetIn = 1'b1; FetchReq = 1'b1; FetchAddr = 16'h1234;
        DataReq = 1'b0; DataWrite = 1'b0; DataAddr = '0; DataWData = '0;
        DmaReq = 1'b0; DmaWrite = 1'b0; DmaAddr = '0; DmaWData = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (GntFetch !== 1'b0 || GntData !== 1'b0 || GntDma !== 1'b0 || MemRE !== 1'b0 ||
                MemWE !== 1'b0 || MemAddr !== 16'h0000 || MemWData !== 8'h00 ||
                FetchBubble !== 1'b1 || PcHold !== 1'b1) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got gnt=%b%b%b re=%b we=%b addr=%h bubble=%b hold=%b want 000 0 0 0000 1 1",
                         i, GntFetch, GntData, GntDma, MemRE, MemWE, MemAddr, FetchBubble, PcHold);
            end
            tick();
        end
        ResetIn = 1'b0;
        // Release cycle is still S_RESET, then FLUSH bubble cycles.
        for (int i = 0; i < 1 + FLUSH; i++) begin
            #2;
            total++;
            if (GntFetch !== 1'b0 || FetchBubble !== 1'b1 || PcHold !== 1'b1 || MemRE !== 1'b0) begin
                bad++;
                $display("FAIL flush_bubble[%0d]: got gntfetch=%b bubble=%b hold=%b re=%b want 0 1 1 0",
                         i, GntFetch, FetchBubble, PcHold, MemRE);
            end
            tick();
        end
        #2;
        total++;
        if (GntFetch !== 1'b1 || MemRE !== 1'b1 || MemAddr !== 16'h1234 || FetchBubble !== 1'b0 || PcHold !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch: got gnt=%b re=%b addr=%h bubble=%b hold=%b want 1 1 1234 0 0",
                     GntFetch, MemRE, MemAddr, FetchBubble, PcHold);
        end
        tick();
    endtask

    task automatic test_data_priority();
        DataReq = 1'b1; DataWrite = 1'b1; DataAddr = 16'h8000; DataWData = 8'hA5; FetchReq = 1'b1;
        #2;
        total++;
        if (GntData !== 1'b1 || GntFetch !== 1'b0 || MemWE !== 1'b1 || MemRE !== 1'b0 ||
            MemAddr !== 16'h8000 || MemWData !== 8'hA5 || FetchBubble !== 1'b1 || PcHold !== 1'b1) begin
            bad++;
            $display("FAIL data_store: got gd=%b gf=%b we=%b re=%b addr=%h wd=%h bubble=%b hold=%b want 1 0 1 0 8000 a5 1 1",
                     GntData, GntFetch, MemWE, MemRE, MemAddr, MemWData, FetchBubble, PcHold);
        end
        tick();
        DataWrite = 1'b0; DataAddr = 16'h4001; DataWData = 8'h5A;
        #2;
        total++;
        if (GntData !== 1'b1 || MemRE !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 16'h4001 || MemWData !== 8'h00) begin
            bad++;
            $display("FAIL data_load: got gd=%b re=%b we=%b addr=%h wd=%h want 1 1 0 4001 00",
                     GntData, MemRE, MemWE, MemAddr, MemWData);
        end
        tick();
        DataReq = 1'b0;
        tick();
    endtask

    task automatic test_dma_burst();
        DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddr = 16'h2000; FetchReq = 1'b1; FetchAddr = 16'h0100;
        for (int i = 0; i < 12; i++) begin
            bit exp_fetch;
            exp_fetch = ((i % 5) == 4);
            #2;
            total++;
            if (GntFetch !== exp_fetch || GntDma !== !exp_fetch ||
                MemAddr !== (exp_fetch ? 16'h0100 : 16'h2000) || MemRE !== 1'b1) begin
                bad++;
                $display("FAIL dma_burst[%0d]: got gf=%b gm=%b addr=%h re=%b want gf=%b gm=%b",
                         i, GntFetch, GntDma, MemAddr, MemRE, exp_fetch, !exp_fetch);
            end
            tick();
        end
        DmaReq = 1'b0; FetchReq = 1'b0;
        tick();
    endtask

    task automatic test_dma_only();
        DmaReq = 1'b1; DmaWrite = 1'b1; DmaAddr = 16'h3300; DmaWData = 8'h3C; FetchReq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            total++;
            if (GntDma !== 1'b1 || MemWE !== 1'b1 || MemWData !== 8'h3C || MemAddr !== 16'h3300 || FetchBubble !== 1'b1) begin
                bad++;
                $display("FAIL dma_only[%0d]: got gm=%b we=%b wd=%h addr=%h bubble=%b want 1 1 3c 3300 1",
                         i, GntDma, MemWE, MemWData, MemAddr, FetchBubble);
            end
            tick();
        end
        DmaReq = 1'b0;
        tick();
    endtask

    task automatic test_all_three();
        DmaReq = 1'b1; DmaWrite = 1'b0; FetchReq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            total++;
            if (GntDma !== 1'b1) begin
                bad++;
                $display("FAIL prime_burst[%0d]: got gm=%b want 1", i, GntDma);
            end
            tick();
        end
        DataReq = 1'b1; DataWrite = 1'b0; DataAddr = 16'h0777;
        #2;
        total++;
        if (GntData !== 1'b1 || GntDma !== 1'b0 || GntFetch !== 1'b0 || MemAddr !== 16'h0777) begin
            bad++;
            $display("FAIL all_three_grant: got gd=%b gm=%b gf=%b addr=%h want 1 0 0 0777",
                     GntData, GntDma, GntFetch, MemAddr);
        end
        tick();
        total++;
        if (dut.u_burst.burst_cnt_q !== 3'd2) begin
            bad++;
            $display("FAIL burst_hold_on_data: got %0d want 2", dut.u_burst.burst_cnt_q);
        end
        DataReq = 1'b0;
        #2;
        total++;
        if (GntDma !== 1'b1 || GntFetch !== 1'b0) begin
            bad++;
            $display("FAIL dma_after_data: got gm=%b gf=%b want 1 0", GntDma, GntFetch);
        end
        tick();
        total++;
        if (dut.u_burst.burst_cnt_q !== 3'd3) begin
            bad++;
            $display("FAIL burst_inc_after_data: got %0d want 3", dut.u_burst.burst_cnt_q);
        end
        DmaReq = 1'b0; FetchReq = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_dma();
        DmaReq = 1'b1; DmaWrite = 1'b1; DmaAddr = 16'h5500; DmaWData = 8'hC3; FetchReq = 1'b1;
        #2;
        total++;
        if (GntDma !== 1'b1 || MemWE !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_dma: got gm=%b we=%b want 1 1", GntDma, MemWE);
        end
        tick();
        ResetIn = 1'b1;
        #2;
        total++;
        if (MemWE !== 1'b0 || GntDma !== 1'b0 || MemAddr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_kills_write: got we=%b gm=%b addr=%h want 0 0 0000", MemWE, GntDma, MemAddr);
        end
        tick();
        ResetIn = 1'b0;
        #2;
        total++;
        if (GntDma !== 1'b0 || FetchBubble !== 1'b1) begin
            bad++;
            $display("FAIL release_cycle: got gm=%b bubble=%b want 0 1", GntDma, FetchBubble);
        end
        tick();
        for (int i = 0; i < FLUSH; i++) begin
            #2;
            total++;
            if (GntDma !== 1'b1 || MemWE !== 1'b1 || GntFetch !== 1'b0 || FetchBubble !== 1'b1) begin
                bad++;
                $display("FAIL flush_dma[%0d]: got gm=%b we=%b gf=%b bubble=%b want 1 1 0 1",
                         i, GntDma, MemWE, GntFetch, FetchBubble);
            end
            tick();
        end
        // Three flush grants leave one DMA slot before fetch must win.
        #2;
        total++;
        if (GntDma !== 1'b1 || GntFetch !== 1'b0) begin
            bad++;
            $display("FAIL run_dma_4th: got gm=%b gf=%b want 1 0", GntDma, GntFetch);
        end
        tick();
        #2;
        total++;
        if (GntFetch !== 1'b1 || GntDma !== 1'b0) begin
            bad++;
            $display("FAIL run_fetch_after_burst: got gf=%b gm=%b want 1 0", GntFetch, GntDma);
        end
        tick();
        DmaReq = 1'b0; FetchReq = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        #2;
        total++;
        if (GntFetch !== 1'b0 || GntData !== 1'b0 || GntDma !== 1'b0 || MemAddr !== 16'h0000 ||
            MemWData !== 8'h00 || MemRE !== 1'b0 || MemWE !== 1'b0 || FetchBubble !== 1'b1) begin
            bad++;
            $display("FAIL idle_bus: got gnt=%b%b%b addr=%h wd=%h re=%b we=%b bubble=%b want 000 0000 00 0 0 1",
                     GntFetch, GntData, GntDma, MemAddr, MemWData, MemRE, MemWE, FetchBubble);
        end
        tick();
    endtask

    initial begin
        $display("bubble opcode %h", NOP_OPCODE);
        test_reset();
        test_data_priority();
        test_dma_burst();
        test_dma_only();
        test_all_three();
        test_reset_mid_dma();
        test_idle();
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
